// File: rtl/mda_text_terminal.sv
// Byte-stream terminal front end for the MDA display path: keeps a COLS x ROWS
// character buffer with cursor, line wrap and hardware scroll via a rotating top row.
module mda_text_terminal #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam int              DEPTH     = COLS * ROWS;
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [6:0]      COL_MAX   = 7'(COLS - 1);
  localparam logic [4:0]      ROW_MAX   = 5'(ROWS - 1);
  localparam logic [7:0]      COLS_W    = 8'(COLS);
  localparam logic [5:0]      ROWS_W    = 6'(ROWS);
  localparam logic [7:0]      SPACE     = 8'h20;
  localparam logic [7:0]      CH_CR     = 8'h0D;
  localparam logic [7:0]      CH_LF     = 8'h0A;
  localparam logic [7:0]      CH_BS     = 8'h08;
  localparam logic [7:0]      CH_FF     = 8'h0C;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Logical screen row to physical buffer row, rotated by the scroll origin.
  function automatic logic [4:0] phys_row(input logic [4:0] row, input logic [4:0] top);
    logic [5:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= ROWS_W) begin
      return 5'(sum - ROWS_W);
    end else begin
      return sum[4:0];
    end
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic [6:0]    clr_col_q, clr_col_d;
  logic [4:0]    clr_row_q, clr_row_d;
  logic [4:0]    top_q, top_d;
  logic [6:0]    cur_col_q, cur_col_d;
  logic [4:0]    cur_row_q, cur_row_d;
  logic [7:0]    rd_char_q;
  logic [7:0]    mem_q [DEPTH];

  logic          accept_s;
  logic          is_ctrl_s;
  logic          do_lf_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [7:0]    wr_data_s;
  logic          rd_in_range_s;
  logic [AW-1:0] rd_addr_s;

  assign accept_s      = in_valid && (state_q == ST_IDLE);
  assign is_ctrl_s     = (in_data == CH_CR) || (in_data == CH_LF) ||
                         (in_data == CH_BS) || (in_data == CH_FF);
  assign rd_in_range_s = ({1'b0, rd_col} < COLS_W) && ({1'b0, rd_row} < ROWS_W);
  assign rd_addr_s     = cell_addr(phys_row(rd_row, top_q), rd_col);
  assign rd_char       = rd_char_q;
  assign cursor_col    = cur_col_q;
  assign cursor_row    = cur_row_q;

  // State register and terminal bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= {AW{1'b0}};
      clr_col_q   <= 7'd0;
      clr_row_q   <= 5'd0;
      top_q       <= 5'd0;
      cur_col_q   <= 7'd0;
      cur_row_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      clr_col_q   <= clr_col_d;
      clr_row_q   <= clr_row_d;
      top_q       <= top_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
    end
  end

  // Next-state: sweep counters, byte decode, cursor motion and scroll.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    clr_col_d   = clr_col_q;
    clr_row_d   = clr_row_q;
    top_d       = top_q;
    cur_col_d   = cur_col_q;
    cur_row_d   = cur_row_q;
    do_lf_s     = 1'b0;
    case (state_q)
      ST_INIT: begin
        top_d     = 5'd0;
        cur_col_d = 7'd0;
        cur_row_d = 5'd0;
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          init_addr_d = {AW{1'b0}};
        end else begin
          init_addr_d = init_addr_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_CLEAR: begin
        if (clr_col_q == COL_MAX) begin
          state_d   = ST_IDLE;
          clr_col_d = 7'd0;
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end
      ST_IDLE: begin
        if (accept_s) begin
          case (in_data)
            CH_CR: cur_col_d = 7'd0;
            CH_LF: do_lf_s = 1'b1;
            CH_BS: begin
              if (cur_col_q != 7'd0) begin
                cur_col_d = cur_col_q - 7'd1;
              end else begin
                cur_col_d = cur_col_q;
              end
            end
            CH_FF: begin
              state_d     = ST_INIT;
              init_addr_d = {AW{1'b0}};
              top_d       = 5'd0;
              cur_col_d   = 7'd0;
              cur_row_d   = 5'd0;
            end
            default: begin
              if (cur_col_q < COL_MAX) begin
                cur_col_d = cur_col_q + 7'd1;
              end else begin
                cur_col_d = 7'd0;
                do_lf_s   = 1'b1;
              end
            end
          endcase
          // Bottom-row line feed rotates the origin and blanks the row that becomes the new bottom.
          if (do_lf_s) begin
            if (cur_row_q < ROW_MAX) begin
              cur_row_d = cur_row_q + 5'd1;
            end else begin
              clr_row_d = top_q;
              top_d     = (top_q == ROW_MAX) ? 5'd0 : top_q + 5'd1;
              clr_col_d = 7'd0;
              state_d   = ST_CLEAR;
            end
          end else begin
            cur_row_d = cur_row_d;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs and buffer write port selection.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = {AW{1'b0}};
    wr_data_s = SPACE;
    case (state_q)
      ST_INIT: begin
        busy      = 1'b1;
        wr_en_s   = 1'b1;
        wr_addr_s = init_addr_q;
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        wr_en_s   = 1'b1;
        wr_addr_s = cell_addr(clr_row_q, clr_col_q);
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept_s && !is_ctrl_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = cell_addr(phys_row(cur_row_q, top_q), cur_col_q);
          wr_data_s = in_data;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: busy = 1'b1;
    endcase
  end

  // Character storage write port.
  always_ff @(posedge clock) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  // Display read port; sees the old value when the same cell is written this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_char_q <= 8'h00;
    end else if (rd_in_range_s) begin
      rd_char_q <= mem_q[rd_addr_s];
    end else begin
      rd_char_q <= 8'h00;
    end
  end

endmodule

// File: tb/tb_mda_text_terminal.sv
// Self-checking bench for mda_text_terminal: a logical screen model feeds a read
// scoreboard, and handshake timing is measured directly on in_ready.
module tb_mda_text_terminal;
  localparam int COLS = 80;
  localparam int ROWS = 25;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [6:0] rd_col = 7'd0;
  logic [4:0] rd_row = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model [ROWS][COLS];
  int m_col = 0;
  int m_row = 0;

  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         tag_c_q [$];
  int         tag_r_q [$];
  bit         rd_pending = 1'b0;

  mda_text_terminal #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 8'h20;
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void model_lf();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) model[r][c] = model[r+1][c];
      for (int c = 0; c < COLS; c++) model[ROWS-1][c] = 8'h20;
    end
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    case (b)
      8'h0D: m_col = 0;
      8'h0A: model_lf();
      8'h08: if (m_col > 0) m_col--;
      8'h0C: model_clear();
      default: begin
        model[m_row][m_col] = b;
        if (m_col < COLS - 1) m_col++;
        else begin
          m_col = 0;
          model_lf();
        end
      end
    endcase
  endfunction

  task automatic issue_read(input int c, input int r, input logic [7:0] e);
    @(negedge clock);
    if (rd_pending) obs_q.push_back(rd_char);
    rd_col = 7'(c);
    rd_row = 5'(r);
    exp_q.push_back(e);
    tag_c_q.push_back(c);
    tag_r_q.push_back(r);
    rd_pending = 1'b1;
  endtask

  task automatic flush_reads();
    @(negedge clock);
    if (rd_pending) obs_q.push_back(rd_char);
    rd_pending = 1'b0;
  endtask

  task automatic read_screen();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) issue_read(c, r, model[r][c]);
    flush_reads();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    model_apply(b);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] e, o;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    n_cmp++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin n_bad++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row); end
    n_cmp++; if (rd_char !== 8'h00) begin n_bad++; $display("FAIL rst_rd_char: got %h want 00", rd_char); end
    @(negedge clock);
    reset = 1'b0;
    wait_ready(n);
    n_cmp++; if (n !== 2000) begin n_bad++; $display("FAIL init_len: got %0d want 2000", n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL init_busy: got %b want 0", busy); end
    model_clear();
    read_screen();
    issue_read(80, 0, 8'h00);
    issue_read(0, 25, 8'h00);
    issue_read(127, 31, 8'h00);
    flush_reads();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL reset_cell(%0d,%0d): got %h want %h", tag_c_q[0], tag_r_q[0], o, e);
      end
      void'(tag_c_q.pop_front()); void'(tag_r_q.pop_front());
    end
  endtask

  task automatic test_print_cr_bs();
    logic [7:0] seq [6] = '{8'h41, 8'h42, 8'h08, 8'h43, 8'h0D, 8'h44};
    logic [7:0] e, o;
    foreach (seq[i]) send_byte(seq[i]);
    n_cmp++; if (cursor_col !== 7'(m_col) || cursor_row !== 5'(m_row)) begin n_bad++; $display("FAIL pcb_cursor: got (%0d,%0d) want (%0d,%0d)", cursor_col, cursor_row, m_col, m_row); end
    send_byte(8'h0D);
    send_byte(8'h08);
    n_cmp++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin n_bad++; $display("FAIL bs_col0: got (%0d,%0d) want (0,0)", cursor_col, cursor_row); end
    issue_read(0, 0, 8'h44);
    issue_read(1, 0, 8'h43);
    read_screen();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL pcb_cell(%0d,%0d): got %h want %h", tag_c_q[0], tag_r_q[0], o, e);
      end
      void'(tag_c_q.pop_front()); void'(tag_r_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3] = '{8'h61, 8'h62, 8'h63};
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = seq[i];
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clock);
      model_apply(seq[i]);
      @(negedge clock);
    end
    in_valid = 1'b0;
    n_cmp++; if (cursor_col !== 7'(m_col) || cursor_row !== 5'(m_row)) begin n_bad++; $display("FAIL b2b_cursor: got (%0d,%0d) want (%0d,%0d)", cursor_col, cursor_row, m_col, m_row); end
  endtask

  task automatic test_wrap();
    logic [7:0] e, o;
    send_byte(8'h0D);
    repeat (3) send_byte(8'h0A);
    repeat (78) send_byte(8'h2E);
    send_byte(8'h78); send_byte(8'h79); send_byte(8'h7A);
    n_cmp++; if (cursor_col !== 7'd1 || cursor_row !== 5'd4) begin n_bad++; $display("FAIL wrap_cursor: got (%0d,%0d) want (1,4)", cursor_col, cursor_row); end
    issue_read(78, 3, 8'h78);
    issue_read(79, 3, 8'h79);
    issue_read(0, 4, 8'h7A);
    read_screen();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL wrap_cell(%0d,%0d): got %h want %h", tag_c_q[0], tag_r_q[0], o, e);
      end
      void'(tag_c_q.pop_front()); void'(tag_r_q.pop_front());
    end
  endtask

  task automatic test_scroll();
    int n;
    logic [7:0] e, o;
    send_byte(8'h0C);
    wait_ready(n);
    n_cmp++; if (n !== 2000) begin n_bad++; $display("FAIL ff_len: got %0d want 2000", n); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < ((r == ROWS - 1) ? COLS - 1 : COLS); c++) send_byte(8'(8'h40 + r));
    n_cmp++; if (cursor_col !== 7'd79 || cursor_row !== 5'd24) begin n_bad++; $display("FAIL fill_cursor: got (%0d,%0d) want (79,24)", cursor_col, cursor_row); end
    for (int s = 1; s <= ROWS; s++) begin
      send_byte(8'h0A);
      wait_ready(n);
      n_cmp++; if (n !== 80) begin n_bad++; $display("FAIL scroll_len[%0d]: got %0d want 80", s, n); end
      n_cmp++; if (cursor_row !== 5'd24) begin n_bad++; $display("FAIL scroll_row[%0d]: got %0d want 24", s, cursor_row); end
      if (s == 1 || s == 13) read_screen();
    end
    send_byte(8'h0D);
    send_byte(8'h5A);
    read_screen();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL scroll_cell(%0d,%0d): got %h want %h", tag_c_q[0], tag_r_q[0], o, e);
      end
      void'(tag_c_q.pop_front()); void'(tag_r_q.pop_front());
    end
  endtask

  task automatic test_ff_back_to_back();
    int n;
    logic [7:0] e, o;
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ffb_pre_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h0C;
    @(posedge clock);
    model_apply(8'h0C);
    @(negedge clock);
    in_data = 8'h51;
    wait_ready(n);
    n_cmp++; if (n !== 2000) begin n_bad++; $display("FAIL ffb_len: got %0d want 2000", n); end
    @(posedge clock);
    model_apply(8'h51);
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++; if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin n_bad++; $display("FAIL ffb_cursor: got (%0d,%0d) want (1,0)", cursor_col, cursor_row); end
    issue_read(0, 0, 8'h51);
    read_screen();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL ffb_cell(%0d,%0d): got %h want %h", tag_c_q[0], tag_r_q[0], o, e);
      end
      void'(tag_c_q.pop_front()); void'(tag_r_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [7:0] e, o;
    while (m_row < ROWS - 1) send_byte(8'h0A);
    send_byte(8'h0A);
    repeat (9) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmc_busy: got %b want 1", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_ready(n);
    n_cmp++; if (n !== 2000) begin n_bad++; $display("FAIL rmc_init_len: got %0d want 2000", n); end
    n_cmp++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin n_bad++; $display("FAIL rmc_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row); end
    model_clear();
    send_byte(8'h52);
    read_screen();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL rmc_cell(%0d,%0d): got %h want %h", tag_c_q[0], tag_r_q[0], o, e);
      end
      void'(tag_c_q.pop_front()); void'(tag_r_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_print_cr_bs();
    test_back_to_back();
    test_wrap();
    test_scroll();
    test_ff_back_to_back();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mda_text_terminal.md
# mda_text_terminal

Character-stream front end for the MDA display path. Accepts a byte stream (ASCII/CP437 plus a few control codes) over a valid/ready handshake and maintains an 80×25 character buffer with cursor, line wrap and hardware scroll. It sits directly upstream of the MDA timing/font core. That core presents a cell column/row each character time and receives the 8-bit glyph code to feed its font ROM.

## Interface

Parameters:
- COLS, 80, text columns; must be ≤ 128.
- ROWS, 25, text rows; must be ≤ 32.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a byte to consume.
- in_data  in  8  character or control byte.
- in_ready  out  1  block can accept a byte this cycle.
- rd_col  in  7  display cell column, 0..COLS-1.
- rd_row  in  5  display cell row, 0..ROWS-1.
- rd_char  out  8  glyph code for (rd_col, rd_row), registered.
- cursor_col  out  7  current write column.
- cursor_row  out  5  current write row (logical; 0 = top of screen).
- busy  out  1  high in INIT or CLEAR.

## Operation

Storage and scroll:
- Buffer has COLS*ROWS bytes, two ports:
  - Display read port.
  - Terminal write port.
- Physical row = (logical row + top) mod ROWS. `top` is a 5-bit register.
- Physical address = phys_row*COLS + col.
- Wrap on `top`: top == ROWS-1 increments to 0.

States:
- INIT
  - Writes 0x20 to every cell, address 0..COLS*ROWS-1, one per cycle.
  - Sets top=0 and cursor=(0,0).
  - Goes to IDLE after the last cell.
- IDLE
  - in_ready=1.
  - A byte is accepted when in_valid && in_ready.
- CLEAR
  - Writes 0x20 to the COLS cells of physical row `clr_row`, one per cycle.
  - Returns to IDLE after col COLS-1.

Byte handling (on accept in IDLE):
- 0x0D CR: col←0.
- 0x0A LF:
  - row<ROWS-1: row←row+1.
  - Otherwise: scroll.
- 0x08 BS:
  - col>0: col←col-1.
  - col=0: no change, nothing written.
- 0x0C FF: enter INIT. Clears the screen and homes the cursor.
- Any other byte (including other codes <0x20, which are CP437 glyphs): written at the cursor.
  - col<COLS-1: col←col+1.
  - Otherwise: col←0 and LF behaviour (advance row or scroll).
- Scroll:
  - clr_row←top.
  - top←top+1 (mod ROWS).
  - Cursor row stays ROWS-1.
  - Enter CLEAR.

Read port:
- rd_char is valid one cycle after rd_col/rd_row are applied.
- rd_col≥COLS or rd_row≥ROWS gives rd_char=0x00.
- Reads are not stalled by INIT or CLEAR.
- A cell being cleared returns either its old value or 0x20.
- Read and write to the same cell in the same cycle returns the old value (read-before-write).

Reset:
- Overrides everything, including a CLEAR or INIT in progress.
- Restarts INIT from address 0.

## Timing

Reset values (cycle in which reset is high):
- in_ready=0, busy=1.
- cursor_col=0, cursor_row=0.
- rd_char=0x00, top=0.
- State = INIT, address 0.

Post-reset sequence:
- First cycle with reset low writes address 0.
- in_ready=1 exactly COLS*ROWS cycles later (2000 with defaults).
- busy falls in the same cycle.

Cursor and accept timing:
- Cursor outputs update in the cycle after an accept.
- Printable/CR/BS/non-scrolling LF take one cycle; in_ready stays 1, so back-to-back accepts run at 1 byte/cycle.
- Scroll: in_ready=0 for exactly COLS cycles after the accepting edge, then returns to 1.
- FF: in_ready=0 for exactly COLS*ROWS cycles after the accepting edge.

Other rules:
- in_data is ignored when in_valid=0 or in_ready=0. It does not need to be held stable once accepted.
- Only one accept per cycle; no input buffering.

## Test plan

1. **Reset/INIT:** reset for 3 cycles, then release, then sweep the full read port → in_ready rises at cycle 2000; every cell reads 0x20; out-of-range (80,0) reads 0x00.
2. **Printable, CR, BS:** send 'A','B',0x08,'C',0x0D,'D' → (0,0)='D', (1,0)='C'; cursor=(1,0); BS at col 0 leaves cursor unchanged.
3. **Line wrap:** from cursor (78,3) send 'x','y','z' → (78,3)='x', (79,3)='y', (0,4)='z'; cursor=(1,4).
4. **Scroll:** fill all rows with their row index, cursor at row 24, then send 0x0A →
   - in_ready low for exactly 80 cycles.
   - Afterwards display row 0 shows old row 1; row 23 shows old row 24; row 24 is all 0x20.
   - Cursor row=24.
   - Repeat 25 scrolls to verify `top` wraps.
5. **Form feed and back-to-back:** send 0x0C with in_valid held high and 'Q' queued next → 'Q' accepted exactly 2000 cycles later at (0,0); all other cells are 0x20.
6. **Reset mid-CLEAR:** assert reset 10 cycles into a scroll → full INIT runs, all cells 0x20, cursor=(0,0), top=0.
